// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_e;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned TMO_W = 8;

  // Reload value for a multi-cycle counter whose first cycle is spent in RUN.
  function automatic logic [CNT_W-1:0] cnt_reload(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_to_reg_i,
  input  logic       ex_reg_wr_en_i,
  output logic       lu_hit_o
);

  always_comb begin
    lu_hit_o = ex_mem_to_reg_i & ex_reg_wr_en_i & (ex_rd_i != '0) &
               ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use bubbles, redirect flushes, memory waits.
// Optional saturating performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_id_Rs1,
  input  logic [4:0]  i_id_Rs2,
  input  logic        i_id_Rs1Used,
  input  logic        i_id_Rs2Used,
  input  logic [4:0]  i_ex_RegDst,
  input  logic        i_ex_MemToReg,
  input  logic        i_ex_RegWrEn,
  input  logic        i_ex_Redirect,
  input  logic        i_mem_Req,
  input  logic        i_mem_Ready,
  output logic        o_pc_stall,
  output logic        o_ifid_stall,
  output logic        o_ifid_flush,
  output logic        o_idex_stall,
  output logic        o_idex_flush,
  output logic        o_exmem_stall,
  output logic        o_pc_redirect,
  output logic        o_mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt,
`endif
  output logic [1:0]  o_state
);

  localparam logic [CNT_W-1:0] LU_RELOAD = cnt_reload(LU_CYCLES);
  localparam logic [CNT_W-1:0] FL_RELOAD = cnt_reload(FLUSH_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             lu_hit;
  logic             mem_block;
  logic             tmo_hit;

  hazard_detect u_detect (
    .id_rs1_i        (i_id_Rs1),
    .id_rs2_i        (i_id_Rs2),
    .id_rs1_used_i   (i_id_Rs1Used),
    .id_rs2_used_i   (i_id_Rs2Used),
    .ex_rd_i         (i_ex_RegDst),
    .ex_mem_to_reg_i (i_ex_MemToReg),
    .ex_reg_wr_en_i  (i_ex_RegWrEn),
    .lu_hit_o        (lu_hit)
  );

  assign mem_block = i_mem_Req & ~i_mem_Ready;
  assign tmo_hit   = (tmo_cnt_q >= TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HZ_RUN;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_block) begin
          state_d   = HZ_MEM_WAIT;
          tmo_cnt_d = TMO_W'(1);
        end else if (i_ex_Redirect) begin
          if (FLUSH_CYCLES > 1) begin
            state_d  = HZ_FLUSH;
            fl_cnt_d = FL_RELOAD;
          end
        end else if (lu_hit && LU_CYCLES > 1) begin
          state_d  = HZ_LU_STALL;
          lu_cnt_d = LU_RELOAD;
        end
      end
      HZ_LU_STALL: begin
        // lu_cnt is held across a memory wait so the remaining bubbles resume afterwards
        if (mem_block) begin
          state_d   = HZ_MEM_WAIT;
          tmo_cnt_d = TMO_W'(1);
        end else if (lu_cnt_q <= CNT_W'(1)) begin
          state_d  = HZ_RUN;
          lu_cnt_d = '0;
        end else begin
          lu_cnt_d = lu_cnt_q - CNT_W'(1);
        end
      end
      HZ_FLUSH: begin
        // A memory wait abandons the rest of the flush window
        if (mem_block) begin
          state_d   = HZ_MEM_WAIT;
          tmo_cnt_d = TMO_W'(1);
          fl_cnt_d  = '0;
        end else if (i_ex_Redirect) begin
          fl_cnt_d = FL_RELOAD;
        end else if (fl_cnt_q <= CNT_W'(1)) begin
          state_d  = HZ_RUN;
          fl_cnt_d = '0;
        end else begin
          fl_cnt_d = fl_cnt_q - CNT_W'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (!mem_block) begin
          state_d   = (lu_cnt_q != '0) ? HZ_LU_STALL : HZ_RUN;
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d    = HZ_RUN;
          tmo_cnt_d  = '0;
          lu_cnt_d   = '0;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_stall  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_stall = 1'b0;
    o_pc_redirect = 1'b0;
    if ((state_q != HZ_MEM_WAIT && mem_block) ||
        (state_q == HZ_MEM_WAIT && mem_block && !tmo_hit)) begin
      o_pc_stall    = 1'b1;
      o_ifid_stall  = 1'b1;
      o_idex_stall  = 1'b1;
      o_exmem_stall = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN, HZ_FLUSH: begin
          if (i_ex_Redirect) begin
            o_pc_redirect = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
          end else if (state_q == HZ_FLUSH) begin
            o_ifid_flush = 1'b1;
          end else if (lu_hit) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
          end
        end
        HZ_LU_STALL: begin
          o_pc_stall   = 1'b1;
          o_ifid_stall = 1'b1;
          o_idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_timeout = tmo_flag_q;
  assign o_state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (o_pc_stall && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (o_pc_redirect && perf_flush_q != '1)
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign o_perf_stall_cnt = perf_stall_q;
  assign o_perf_flush_cnt = perf_flush_q;
`endif

endmodule
